// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
// Shared definitions for the axis_fifo_status slice:
//   pause_state_t  output pause FSM state encoding
//   count_width()  width of the depth / frame counters
//   *_offset()     field positions of tkeep/tlast/tuser inside a stored word
//   word_width()   total width of one stored word
package axis_fifo_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } pause_state_t;

    // Counters must hold a completely full RAM plus every output stage.
    function automatic int count_width(input int aw, input int pipe);
        return $clog2((2 ** aw) + pipe + 1);
    endfunction

    // Stored word layout, LSB first: tdata | tkeep | tlast | tuser
    function automatic int keep_offset(input int dw);
        return dw;
    endfunction

    function automatic int last_offset(input int dw, input int kw);
        return dw + kw;
    endfunction

    function automatic int user_offset(input int dw, input int kw);
        return dw + kw + 1;
    endfunction

    function automatic int word_width(input int dw, input int kw, input int uw);
        return dw + kw + 1 + uw;
    endfunction

endpackage

// File: rtl/axis_fifo_status_cnt.sv
// axis_fifo_status_cnt
// Registered up/down counter with two registered threshold flags that are
// computed from the next count value, so flags and count change together.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inc, dec            count up / down this cycle (both -> unchanged)
//   thresh_hi/lo        thresholds for flag_hi (>=) and flag_lo (<=)
//   count               current count
//   flag_hi, flag_lo    count >= thresh_hi, count <= thresh_lo
module axis_fifo_status_cnt
    import axis_fifo_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic [CW-1:0] thresh_hi,
    input  logic [CW-1:0] thresh_lo,
    output logic [CW-1:0] count,
    output logic          flag_hi,
    output logic          flag_lo
);

    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (inc && !dec) begin
            count_nxt = count + CW'(1);
        end else if (dec && !inc) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            flag_hi <= 1'b0;
            flag_lo <= 1'b1;
        end else begin
            count   <= count_nxt;
            flag_hi <= (count_nxt >= thresh_hi);
            flag_lo <= (count_nxt <= thresh_lo);
        end
    end

endmodule

// File: rtl/axis_fifo_status.sv
// axis_fifo_status
// Single-clock AXI4-Stream FIFO with fill-level reporting, almost-full /
// almost-empty flags, a count of complete frames held, and a pause request
// that stops the output only at a frame boundary.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_axis_*                         stream input (tready = RAM not full)
//   m_axis_*                         stream output
//   cfg_afull_thresh/aempty_thresh   flag thresholds in words
//   pause_req / pause_ack            stop output at next frame boundary / stopped
//   status_depth                     words held (RAM plus valid output stages)
//   status_frames                    tlast words held
//   status_almost_full/empty         depth >= afull_thresh / depth <= aempty_thresh
//
// Pause FSM
//   state      | meaning
//   ST_RUN     | output flows normally
//   ST_PAUSED  | output held off (m_axis_tvalid forced low), pause_ack high
module axis_fifo_status
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH           = 1024,
    parameter int DATA_WIDTH      = 8,
    parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH      = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE     = 1,
    parameter int USER_ENABLE     = 1,
    parameter int USER_WIDTH      = 1,
    parameter int PIPELINE_OUTPUT = 2,
    localparam int AW             = $clog2(DEPTH),
    localparam int CW             = count_width(AW, PIPELINE_OUTPUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic [CW-1:0]         cfg_afull_thresh,
    input  logic [CW-1:0]         cfg_aempty_thresh,
    input  logic                  pause_req,
    output logic                  pause_ack,

    output logic [CW-1:0]         status_depth,
    output logic [CW-1:0]         status_frames,
    output logic                  status_almost_full,
    output logic                  status_almost_empty
);

    localparam int P    = PIPELINE_OUTPUT;
    localparam int WW   = word_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH);
    localparam int KOFS = keep_offset(DATA_WIDTH);
    localparam int LOFS = last_offset(DATA_WIDTH, KEEP_WIDTH);
    localparam int UOFS = user_offset(DATA_WIDTH, KEEP_WIDTH);

    if (PIPELINE_OUTPUT < 1) begin : g_pipe_check
        $error("axis_fifo_status: PIPELINE_OUTPUT must be at least 1");
    end

    logic [WW-1:0]  mem [2**AW];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           empty;
    logic           full;

    logic [P-1:0]   pipe_valid;
    logic [WW-1:0]  pipe_data [P];
    logic [P-1:0]   shift;
    logic           bubble_acc;

    logic [WW-1:0]  wr_word;
    logic [WW-1:0]  out_word;
    logic           in_fire;
    logic           out_fire;
    logic           out_rdy;
    logic           last_in;
    logic           last_out;

    pause_state_t   state;
    logic           in_frame;
    logic           in_frame_nxt;

    logic           frames_flag_hi_unused;
    logic           frames_flag_lo_unused;

    // Disabled sideband fields are stored as their fixed output value, so
    // the read side never needs to know which fields are enabled for tlast.
    always_comb begin
        wr_word                         = '0;
        wr_word[DATA_WIDTH-1:0]         = s_axis_tdata;
        wr_word[KOFS +: KEEP_WIDTH]     = (KEEP_ENABLE != 0) ? s_axis_tkeep : '0;
        wr_word[LOFS]                   = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
        wr_word[UOFS +: USER_WIDTH]     = (USER_ENABLE != 0) ? s_axis_tuser : '0;
    end

    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr == (rd_ptr ^ {1'b1, {AW{1'b0}}}));
    assign s_axis_tready = !full;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign last_in       = wr_word[LOFS];

    assign out_word      = pipe_data[P-1];
    assign out_rdy       = m_axis_tready && !pause_ack;
    assign m_axis_tvalid = pipe_valid[P-1] && !pause_ack;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign last_out      = out_word[LOFS];

    assign m_axis_tdata  = out_word[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? out_word[KOFS +: KEEP_WIDTH] : '1;
    assign m_axis_tlast  = last_out;
    assign m_axis_tuser  = (USER_ENABLE != 0) ? out_word[UOFS +: USER_WIDTH] : '0;

    // A stage advances when the consumer takes a word or when it or any
    // later stage is empty, so bubbles collapse toward the output.
    always_comb begin
        shift      = '0;
        bubble_acc = out_rdy;
        for (int i = P - 1; i >= 0; i--) begin
            bubble_acc = bubble_acc || !pipe_valid[i];
            shift[i]   = bubble_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (shift[0]) begin
            pipe_data[0] <= mem[rd_ptr[AW-1:0]];
        end
        for (int i = 1; i < P; i++) begin
            if (shift[i]) begin
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pipe_valid <= '0;
        end else begin
            if (in_fire) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (shift[0]) begin
                pipe_valid[0] <= !empty;
                if (!empty) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end
            for (int i = 1; i < P; i++) begin
                if (shift[i]) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                end
            end
        end
    end

    // Frame position includes this cycle's transfer, so a pause requested
    // while the closing tlast leaves takes hold on the very next cycle, and
    // a frame whose first word leaves this cycle is never cut.
    always_comb begin
        in_frame_nxt = in_frame;
        if (out_fire) begin
            in_frame_nxt = !last_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            in_frame  <= 1'b0;
            pause_ack <= 1'b0;
        end else begin
            in_frame <= in_frame_nxt;
            case (state)
                ST_RUN: begin
                    if (pause_req && !in_frame_nxt) begin
                        state     <= ST_PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause_req) begin
                        state     <= ST_RUN;
                        pause_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    pause_ack <= 1'b0;
                end
            endcase
        end
    end

    axis_fifo_status_cnt #(.CW(CW)) u_depth_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (in_fire),
        .dec       (out_fire),
        .thresh_hi (cfg_afull_thresh),
        .thresh_lo (cfg_aempty_thresh),
        .count     (status_depth),
        .flag_hi   (status_almost_full),
        .flag_lo   (status_almost_empty)
    );

    axis_fifo_status_cnt #(.CW(CW)) u_frame_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (in_fire && last_in),
        .dec       (out_fire && last_out),
        .thresh_hi ('0),
        .thresh_lo ('0),
        .count     (status_frames),
        .flag_hi   (frames_flag_hi_unused),
        .flag_lo   (frames_flag_lo_unused)
    );

endmodule

// File: tb/tb_axis_fifo_status.sv
module tb_axis_fifo_status;

    localparam int CW = 5;   // DEPTH=16, PIPELINE_OUTPUT=2 -> clog2(19)

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_tdata = '0;
    logic          s_tkeep = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [7:0]    m_tdata;
    logic          m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          m_tuser;
    logic [CW-1:0] afull_th = 5'd2;
    logic [CW-1:0] aempty_th = 5'd0;
    logic          pause_req = 1'b0;
    logic          pause_ack;
    logic [CW-1:0] st_depth;
    logic [CW-1:0] st_frames;
    logic          st_afull;
    logic          st_aempty;

    axis_fifo_status #(
        .DEPTH(16), .DATA_WIDTH(8), .USER_WIDTH(1), .PIPELINE_OUTPUT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .cfg_afull_thresh(afull_th), .cfg_aempty_thresh(aempty_th),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .status_depth(st_depth), .status_frames(st_frames),
        .status_almost_full(st_afull), .status_almost_empty(st_aempty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: queue of {tuser, tlast, tdata} words currently held.
    logic [9:0] q[$];
    int         model_frames = 0;
    bit         in_fired;
    bit         out_fired;
    bit         popped_last;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: handshakes observed mid-cycle, status checked after the edge.
    task automatic step();
        logic [9:0] exp_w;
        @(negedge clk);
        in_fired    = s_tvalid && s_tready;
        out_fired   = m_tvalid && m_tready;
        popped_last = 1'b0;
        if (q.size() < 16)       check("s_tready_room", int'(s_tready), 1);
        else if (q.size() == 18) check("s_tready_full", int'(s_tready), 0);
        if (out_fired) begin
            if (q.size() == 0) begin
                check("pop_with_empty_model", int'(m_tvalid), 0);
            end else begin
                exp_w = q.pop_front();
                check("out_word", int'({m_tuser, m_tlast, m_tdata}), int'(exp_w));
                if (exp_w[8]) begin
                    model_frames--;
                    popped_last = 1'b1;
                end
            end
        end
        if (in_fired) begin
            q.push_back({s_tuser, s_tlast, s_tdata});
            if (s_tlast) model_frames++;
        end
        @(posedge clk);
        #1;
        check("depth", int'(st_depth), q.size());
        check("frames", int'(st_frames), model_frames);
        check("almost_full", int'(st_afull), int'(q.size() >= int'(afull_th)));
        check("almost_empty", int'(st_aempty), int'(q.size() <= int'(aempty_th)));
    endtask

    task automatic drain(input string name);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < 200 && q.size() > 0; c++) step();
        check(name, q.size(), 0);
        step();
        check("idle_tvalid", int'(m_tvalid), 0);
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       pr;
        int         depth;
        int         frames;
        logic       tvalid;
        logic [7:0] tdata;
        logic       ack;
        logic       afull;
        logic       aempty;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        int   acc;
        int   bubbles;
        int   fired;

        // Directed sequence from an empty FIFO, afull_th=2, aempty_th=0.
        vt[0] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_depth", int'(st_depth), 0);
        check("rst_frames", int'(st_frames), 0);
        check("rst_ack", int'(pause_ack), 0);
        check("rst_aempty", int'(st_aempty), 1);
        check("rst_afull", int'(st_afull), 0);
        check("rst_tready", int'(s_tready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            s_tvalid  = vt[i].sv;
            s_tdata   = vt[i].sd;
            s_tlast   = vt[i].sl;
            m_tready  = vt[i].mr;
            pause_req = vt[i].pr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_depth", i), int'(st_depth), vt[i].depth);
            check($sformatf("vec%0d_frames", i), int'(st_frames), vt[i].frames);
            check($sformatf("vec%0d_tvalid", i), int'(m_tvalid), int'(vt[i].tvalid));
            check($sformatf("vec%0d_ack", i), int'(pause_ack), int'(vt[i].ack));
            check($sformatf("vec%0d_afull", i), int'(st_afull), int'(vt[i].afull));
            check($sformatf("vec%0d_aempty", i), int'(st_aempty), int'(vt[i].aempty));
            check($sformatf("vec%0d_tready", i), int'(s_tready), 1);
            if (vt[i].tvalid) begin
                check($sformatf("vec%0d_tdata", i), int'(m_tdata), int'(vt[i].tdata));
                check($sformatf("vec%0d_tkeep", i), int'(m_tkeep), 1);
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; pause_req = 1'b0;

        // Fill until backpressure: 16 RAM words + 2 output stages
        afull_th  = 5'd16;
        aempty_th = 5'd1;
        step();
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            s_tdata = 8'(acc);
            s_tlast = (acc % 4 == 3);
            step();
            if (in_fired) acc++;
        end
        check("fill_accepted", acc, 18);
        check("fill_depth", int'(st_depth), 18);
        check("fill_tready", int'(s_tready), 0);
        check("fill_afull", int'(st_afull), 1);
        drain("fill_drain");
        check("drain_aempty", int'(st_aempty), 1);

        // Streaming, both sides always ready
        acc = 0;
        bubbles = 0;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            s_tdata = 8'(acc);
            s_tlast = ($urandom_range(0, 3) == 0);
            s_tuser = 1'($urandom_range(0, 1));
            step();
            if (in_fired) acc++;
            if (c >= 4 && !out_fired) bubbles++;
        end
        check("stream_accepted", acc, 1000);
        check("stream_bubbles", bubbles, 0);
        drain("stream_drain");

        // Pause in the middle of a 4-word frame
        m_tready = 1'b0;
        s_tuser  = 1'b0;
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 12 && acc < 8; c++) begin
            s_tdata = 8'(8'h40 + acc);
            s_tlast = (acc % 4 == 3);
            step();
            if (in_fired) acc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int c = 0; c < 10 && !m_tvalid; c++) step();
        check("pause_setup_tvalid", int'(m_tvalid), 1);
        m_tready = 1'b1;
        step();
        pause_req = 1'b1;
        fired = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_fired) fired++;
            if (popped_last) break;
        end
        check("pause_frame_words", fired, 4);
        check("pause_ack", int'(pause_ack), 1);
        check("pause_tvalid", int'(m_tvalid), 0);
        check("pause_frames", int'(st_frames), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("paused_hold_ack", int'(pause_ack), 1);
            check("paused_hold_tvalid", int'(m_tvalid), 0);
        end
        pause_req = 1'b0;
        step();
        check("resume_ack", int'(pause_ack), 0);
        check("resume_tvalid", int'(m_tvalid), 1);
        check("resume_tdata", int'(m_tdata), 8'h44);
        drain("pause_drain");
        check("pause_frames_end", int'(st_frames), 0);

        // Random handshakes, well past pointer wrap
        acc = 0;
        for (int c = 0; c < 600; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = 8'($urandom);
            s_tlast  = ($urandom_range(0, 3) == 0);
            s_tuser  = 1'($urandom_range(0, 1));
            step();
            if (in_fired) acc++;
        end
        check("rand_wrap", int'(acc > 48), 1);
        drain("rand_drain");

        // Asynchronous reset with data held
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tuser  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_tdata = 8'(8'h10 + c);
            s_tlast = (c == 4);
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("pre_rst_depth", int'(st_depth), 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", int'(m_tvalid), 0);
        check("arst_depth", int'(st_depth), 0);
        check("arst_frames", int'(st_frames), 0);
        check("arst_aempty", int'(st_aempty), 1);
        q.delete();
        model_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        s_tlast  = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("post_rst_lat0", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        check("post_rst_lat1", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        check("post_rst_lat2", int'(m_tvalid), 1);
        check("post_rst_tdata", int'(m_tdata), 8'h5A);
        check("post_rst_depth", int'(st_depth), 1);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", int'(st_depth), 0);
        check("post_rst_done", int'(m_tvalid), 0);

        // Threshold change takes effect on the next edge
        m_tready = 1'b0;
        afull_th = 5'd8;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_tdata = 8'(8'h70 + c);
            step();
        end
        s_tvalid = 1'b0;
        step();
        check("thr_depth", int'(st_depth), 5);
        check("thr_afull_before", int'(st_afull), 0);
        afull_th = 5'd4;
        @(negedge clk);
        check("thr_afull_same_cycle", int'(st_afull), 0);
        @(posedge clk);
        #1;
        check("thr_afull_after", int'(st_afull), 1);
        drain("thr_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
